// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and defaults.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width: enough to count WIDTH steps, never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full-adder cell used as the per-bit datapath of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes operands LSB first over
// WIDTH cycles, then a one-cycle done pulse presents sum and carry-out.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_shift;

  full_adder u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Sum register shifts right with the new bit entering at the MSB; written
  // as shift-then-overwrite so it also works when WIDTH is 1.
  always_comb begin
    w_sum_shift            = r_sum >> 1;
    w_sum_shift[WIDTH-1]   = w_s;
  end

  // Control FSM plus datapath registers; busy/done are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum   <= w_sum_shift;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          if (w_last) begin
            // Counter is left at WIDTH-1 on the final step so it never wraps.
            r_cout  <= w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 and WIDTH=1 instances on one clock.
module tb_serial_adder;
  import serial_adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       rst, start, cin, busy, done, cout;
  logic [7:0] a, b, sum;
  // WIDTH=1 instance
  logic       rst1, start1, a1, b1, cin1, busy1, done1, sum1, cout1;

  int n_cmp = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(DEFAULT_WIDTH)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 addition, entered at a negedge in IDLE, left at a negedge in IDLE.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input logic [7:0] es, input logic ec, input string tag);
    int nb;
    a = av; b = bv; cin = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~av; b = ~bv; cin = ~cv;
    nb = 0;
    for (int i = 0; i < 40 && done !== 1'b1; i++) begin
      if (busy === 1'b1) nb++;
      start = (nb == 3);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busycyc"}, 32'(nb), 32'd8);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_sum_hold"}, 32'(sum), 32'(es));
    $display("op %s a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d", tag, av, bv, cv, sum, cout);
  endtask

  initial begin
    logic [7:0] ra, rb, fa_sum_tab, fa_cout_tab;
    logic       rc;
    logic [8:0] tot;
    int         c, ndone, nd;

    rst = 1'b1; rst1 = 1'b1;
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);

    // Release reset with start presented for the very first edge.
    rst = 1'b0; rst1 = 1'b0;
    run8(8'h03, 8'h05, 1'b0, 8'h08, 1'b0, "add_3_5");
    run8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "ff_0_c1");
    run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ff_ff_c1");
    run8(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, "a5_5a");
    run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "80_80");

    // start held high, a changing every cycle: ops accepted every 10 cycles.
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    ndone = 0;
    for (c = 1; c <= 29; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        check("hold_done_cycle", 32'(c), 32'(9 + 10 * ndone));
        check("hold_sum", 32'(sum), 32'(8'(1 + 10 * ndone + 2)));
        $display("op hold#%0d sum=%02h cout=%0d", ndone, sum, cout);
        ndone++;
      end
      a = a + 8'h01;
    end
    start = 1'b0;
    check("hold_ndone", 32'(ndone), 32'd3);
    repeat (2) @(negedge clk);

    // Reset four cycles into RUN aborts the operation.
    a = 8'h55; b = 8'h66; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) nd++;
    end
    check("midrst_no_activity", 32'(nd), 32'd0);
    $display("op midrst abort busy=%0d done=%0d", busy, done);
    run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "post_rst");

    // WIDTH=1 exhaustive truth table, index = {a,b,cin}.
    fa_sum_tab  = 8'b1001_0110;
    fa_cout_tab = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("w1_busy", 32'(busy1), 32'd1);
      check("w1_early_done", 32'(done1), 32'd0);
      @(negedge clk);
      check("w1_done", 32'(done1), 32'd1);
      check("w1_sum", 32'(sum1), 32'(fa_sum_tab[i]));
      check("w1_cout", 32'(cout1), 32'(fa_cout_tab[i]));
      $display("op w1 a=%0d b=%0d cin=%0d -> s=%0d c=%0d", v[2], v[1], v[0], sum1, cout1);
      @(negedge clk);
    end

    // Random regression on the WIDTH=8 instance.
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      tot = 9'(ra) + 9'(rb) + 9'(rc);
      run8(ra, rb, rc, tot[7:0], tot[8], "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the operand width in bits; legal range 1..32.
REQ-002 The port clk SHALL be input, width 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The port rst SHALL be input, width 1, the reset; reset SHALL be asynchronous and active-high.
REQ-004 The port start SHALL be input, width 1, a request to begin an addition, sampled on the rising edge of clk.
REQ-005 The port a SHALL be input, width WIDTH, operand A, captured when start is accepted.
REQ-006 The port b SHALL be input, width WIDTH, operand B, captured when start is accepted.
REQ-007 The port cin SHALL be input, width 1, the carry-in, captured when start is accepted.
REQ-008 The port busy SHALL be output, width 1, high while bits are being computed.
REQ-009 The port done SHALL be output, width 1, a one-cycle pulse marking that sum and cout are valid.
REQ-010 The port sum SHALL be output, width WIDTH, the registered result.
REQ-011 The port cout SHALL be output, width 1, the registered carry-out.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 In IDLE, the block SHALL accept start=1 at edge k, load shift registers with a and b, load the carry register with cin, clear the bit counter, and enter RUN.
REQ-014 In RUN, each edge SHALL add LSB(A), LSB(B) and carry through one full-adder cell, shift the sum bit into sum at the MSB, shift A and B right by 1, update carry with the cell carry-out, and increment the counter.
REQ-015 RUN SHALL last exactly WIDTH cycles; at edge k+WIDTH, sum SHALL hold (a+b+cin) mod 2^WIDTH, cout SHALL hold bit WIDTH of a+b+cin, and the state SHALL become DONE.
REQ-016 busy SHALL be 1 exactly when the state is RUN.
REQ-017 done SHALL be 1 exactly when the state is DONE, for one cycle, and DONE SHALL unconditionally return to IDLE.
REQ-018 start SHALL be ignored in RUN and DONE, and the operands SHALL NOT be re-sampled.
REQ-019 Back-to-back operation SHALL allow a new start in the first IDLE cycle after DONE, giving a minimum period of WIDTH+2 cycles.
REQ-020 sum and cout SHALL hold their last valid values in IDLE until the next accepted start.
REQ-021 sum and cout SHALL be don't-care during RUN; the bench SHALL check them only when done=1.
REQ-022 The counter SHALL be max(1,$clog2(WIDTH)) bits wide and SHALL NOT wrap within an operation.
REQ-023 WIDTH=1 SHALL give RUN for exactly one cycle.
REQ-024 With operands all ones and cin=1, the block SHALL give sum = all ones and cout=1, with no overflow beyond cout.

Reset
REQ-025 While rst=1, the FSM SHALL be in IDLE, and busy, done, sum, cout, the carry, the counter and the shift registers SHALL all be 0, independent of clk.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release, the block SHALL wait in IDLE for a fresh start.
REQ-027 start coincident with the first edge after rst deasserts SHALL be accepted normally.

Structure
REQ-028 A shared package SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant, for reuse by the bench.
REQ-029 The per-bit addition SHALL be one instance of the existing single-bit full-adder cell, sub-module full_adder (ports a, b, cin, s, cout), and SHALL NOT be re-coded inline.
REQ-030 The remaining logic SHALL be the FSM, the counter, two operand shift registers, the sum shift register and the carry flop, with no other sub-modules.

Verification
REQ-031 WIDTH=8, a=8'h03, b=8'h05, cin=0, start pulse -> busy high 8 cycles, then done for 1 cycle, sum=8'h08, cout=0.
REQ-032 a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-033 start held high continuously with a changing every cycle -> only the operands at the accepting edge are used; one done per WIDTH+2 cycles.
REQ-034 rst asserted 4 cycles into RUN -> busy, done, sum and cout are 0 immediately; no done pulse; a subsequent start with a=8'h10, b=8'h20 gives sum=8'h30.
REQ-035 WIDTH=1, exhaustive {a,b,cin} over all 8 combinations -> sum and cout match the full-adder truth table; done 2 cycles after each start.
REQ-036 Random regression, WIDTH=8, 1000 operations -> {cout,sum} == a+b+cin every done.
